// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains the fifo core into a valid/ready stream.
// A 2-entry skid buffer absorbs the fifo's one-cycle read latency.
// A word still in flight is shown at the head directly from fifo_dataout
// while the buffer is empty. This gives one-cycle read-to-valid latency.
// Reads are credit-limited, so a returning word always has a buffer slot.
module fifo_stream_reader #(
    parameter int WIDTH        = 32,
    parameter int PACKET_LEN   = 16,
    parameter int PKT_CNT_BITS = 16,
    localparam int IDX_W       = (PACKET_LEN > 1) ? $clog2(PACKET_LEN) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [WIDTH-1:0]        fifo_dataout,
    input  logic                    fifo_empty,
    output logic                    fifo_read,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic [IDX_W-1:0]        word_index,
    output logic [PKT_CNT_BITS-1:0] packet_count,
    output logic                    busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PACKET_LEN - 1);

    logic [1:0]       occ;
    logic [1:0]       occ_next;
    logic             inflight;
    logic             rd_ptr;
    logic             wr_ptr;
    logic             pop;
    logic [WIDTH-1:0] buffer [2];

    // Head presentation, pop and credit-limited read request
    always_comb begin
        out_valid = (occ != 2'd0) || inflight;
        out_data  = (occ != 2'd0) ? buffer[rd_ptr] : fifo_dataout;
        pop       = out_valid && out_ready;
        occ_next  = occ + {1'b0, inflight} - {1'b0, pop};
        fifo_read = enable && !fifo_empty && !reset && (occ_next < 2'd2);
        busy      = (occ != 2'd0) || inflight;
        if (PACKET_LEN == 1) begin
            out_last = out_valid;
        end else begin
            out_last = (word_index == LAST_IDX);
        end
    end

    // Occupancy, in-flight flag and buffer pointers
    always_ff @(posedge clk) begin
        if (reset) begin
            occ      <= 2'd0;
            inflight <= 1'b0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
        end else begin
            occ      <= occ_next;
            inflight <= fifo_read;
            if (inflight) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end

    // Capture returning fifo data; the storage itself needs no reset
    always_ff @(posedge clk) begin
        if (inflight) begin
            buffer[wr_ptr] <= fifo_dataout;
        end
    end

    // Packet framing advances only on consumer pops
    always_ff @(posedge clk) begin
        if (reset) begin
            word_index   <= '0;
            packet_count <= '0;
        end else if (pop) begin
            if (out_last) begin
                word_index   <= '0;
                packet_count <= packet_count + PKT_CNT_BITS'(1);
            end else begin
                word_index <= word_index + IDX_W'(1);
            end
        end
    end

endmodule
